// File: rtl/shifter_scheduler_pkg.sv
// Shared types and constants for the shifter scheduler slice.
package shifter_scheduler_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    localparam logic ID_EXEC = 1'b0;
    localparam logic ID_ADDR = 1'b1;

    typedef enum logic [1:0] {
        SS_IDLE  = 2'd0,
        SS_SHIFT = 2'd1,
        SS_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/barrel_shifter.sv
// ARM-style immediate barrel shifter; imm==0 selects LSR/ASR #32 and RRX.
module barrel_shifter
    import shifter_scheduler_pkg::*;
#(
    parameter int WordWidth = WORD_WIDTH
) (
    input  logic [WordWidth-1:0] in_Val,
    input  logic [1:0]           in_Type,
    input  logic [4:0]           in_Imm,
    input  logic                 in_C,
    output logic [WordWidth-1:0] out_Val,
    output logic                 out_Carry
);

    logic zero;
    assign zero = (in_Imm == 5'd0);

    always_comb begin
        out_Val   = in_Val;
        out_Carry = in_C;
        case (in_Type)
            SH_LSL: begin
                if (!zero) begin
                    {out_Carry, out_Val} = {1'b0, in_Val} << in_Imm;
                end
            end
            SH_LSR: begin
                if (zero) begin
                    out_Val   = '0;
                    out_Carry = in_Val[WordWidth-1];
                end else begin
                    {out_Val, out_Carry} = {in_Val, 1'b0} >> in_Imm;
                end
            end
            SH_ASR: begin
                if (zero) begin
                    out_Val   = {WordWidth{in_Val[WordWidth-1]}};
                    out_Carry = in_Val[WordWidth-1];
                end else begin
                    {out_Val, out_Carry} = $signed({in_Val, 1'b0}) >>> in_Imm;
                end
            end
            default: begin
                // imm==0 is RRX: rotate through carry by one
                if (zero) begin
                    out_Val   = {in_C, in_Val[WordWidth-1:1]};
                    out_Carry = in_Val[0];
                end else begin
                    out_Val   = (in_Val >> in_Imm)
                              | (in_Val << (WordWidth - int'(in_Imm)));
                    out_Carry = out_Val[WordWidth-1];
                end
            end
        endcase
    end

endmodule

// File: rtl/shifter_scheduler_decode.sv
// Maps register-specified shift amounts onto the shifter's 5-bit encoding.
module shift_amount_decode
    import shifter_scheduler_pkg::*;
#(
    parameter int WordWidth = WORD_WIDTH
) (
    input  logic [1:0]           in_Type,
    input  logic                 in_ByReg,
    input  logic [7:0]           in_Amt,
    input  logic [WordWidth-1:0] in_Val,
    input  logic                 in_C,
    output logic                 out_Bypass,
    output logic [WordWidth-1:0] out_BypassVal,
    output logic                 out_BypassCarry,
    output logic [4:0]           out_Imm
);

    logic is_zero, is_small, is_32;
    assign is_zero  = (in_Amt == 8'd0);
    assign is_small = (in_Amt < 8'd32);
    assign is_32    = (in_Amt == 8'd32);

    always_comb begin
        out_Bypass      = 1'b0;
        out_BypassVal   = in_Val;
        out_BypassCarry = in_C;
        out_Imm         = in_Amt[4:0];
        if (in_ByReg) begin
            if (is_zero) begin
                out_Bypass = 1'b1;
            end else if (!is_small) begin
                case (in_Type)
                    SH_LSL: begin
                        out_Bypass      = 1'b1;
                        out_BypassVal   = '0;
                        out_BypassCarry = is_32 & in_Val[0];
                    end
                    SH_LSR: begin
                        out_Imm = 5'd0;
                        if (!is_32) begin
                            out_Bypass      = 1'b1;
                            out_BypassVal   = '0;
                            out_BypassCarry = 1'b0;
                        end
                    end
                    SH_ASR: out_Imm = 5'd0;
                    default: begin
                        // whole-word rotations leave Val intact
                        if (in_Amt[4:0] == 5'd0) begin
                            out_Bypass      = 1'b1;
                            out_BypassCarry = in_Val[WordWidth-1];
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/shifter_scheduler.sv
// Round-robin scheduler sharing one barrel shifter between two requesters.
module shifter_scheduler
    import shifter_scheduler_pkg::*;
#(
    parameter int WordWidth = WORD_WIDTH
) (
    input  logic                 in_Clk,
    input  logic                 in_Reset,
    input  logic                 in_Req0_Valid,
    output logic                 out_Req0_Ready,
    input  logic [WordWidth-1:0] in_Req0_Val,
    input  logic [1:0]           in_Req0_Type,
    input  logic                 in_Req0_ByReg,
    input  logic [7:0]           in_Req0_Amt,
    input  logic                 in_Req0_C,
    input  logic                 in_Req1_Valid,
    output logic                 out_Req1_Ready,
    input  logic [WordWidth-1:0] in_Req1_Val,
    input  logic [1:0]           in_Req1_Type,
    input  logic                 in_Req1_ByReg,
    input  logic [7:0]           in_Req1_Amt,
    input  logic                 in_Req1_C,
    output logic                 out_Res_Valid,
    input  logic                 in_Res_Ready,
    output logic [WordWidth-1:0] out_Res_Op2,
    output logic                 out_Res_Carry,
    output logic                 out_Res_Id
);

    state_t               state;
    logic                 last;
    logic [WordWidth-1:0] val_q;
    logic [1:0]           type_q;
    logic                 byreg_q;
    logic [7:0]           amt_q;
    logic                 c_q;
    logic                 id_q;

    logic grant0, grant1, idle;
    assign idle   = (state == SS_IDLE) & ~in_Reset;
    assign grant0 = in_Req0_Valid & (~in_Req1_Valid | (last == ID_ADDR));
    assign grant1 = in_Req1_Valid & (~in_Req0_Valid | (last == ID_EXEC));
    assign out_Req0_Ready = idle & grant0;
    assign out_Req1_Ready = idle & grant1;

    logic                 bypass, bypass_carry, sh_carry;
    logic [WordWidth-1:0] bypass_val, sh_val;
    logic [4:0]           imm;

    shift_amount_decode #(.WordWidth(WordWidth)) u_decode (
        .in_Type        (type_q),
        .in_ByReg       (byreg_q),
        .in_Amt         (amt_q),
        .in_Val         (val_q),
        .in_C           (c_q),
        .out_Bypass     (bypass),
        .out_BypassVal  (bypass_val),
        .out_BypassCarry(bypass_carry),
        .out_Imm        (imm)
    );

    barrel_shifter #(.WordWidth(WordWidth)) u_shifter (
        .in_Val   (val_q),
        .in_Type  (type_q),
        .in_Imm   (imm),
        .in_C     (c_q),
        .out_Val  (sh_val),
        .out_Carry(sh_carry)
    );

    always_ff @(posedge in_Clk) begin
        if (in_Reset) begin
            state         <= SS_IDLE;
            last          <= ID_ADDR;
            val_q         <= '0;
            type_q        <= SH_LSL;
            byreg_q       <= 1'b0;
            amt_q         <= '0;
            c_q           <= 1'b0;
            id_q          <= ID_EXEC;
            out_Res_Valid <= 1'b0;
            out_Res_Op2   <= '0;
            out_Res_Carry <= 1'b0;
            out_Res_Id    <= 1'b0;
        end else begin
            case (state)
                SS_IDLE: begin
                    if (out_Req0_Ready) begin
                        val_q   <= in_Req0_Val;
                        type_q  <= in_Req0_Type;
                        byreg_q <= in_Req0_ByReg;
                        amt_q   <= in_Req0_Amt;
                        c_q     <= in_Req0_C;
                        id_q    <= ID_EXEC;
                        last    <= ID_EXEC;
                        state   <= SS_SHIFT;
                    end else if (out_Req1_Ready) begin
                        val_q   <= in_Req1_Val;
                        type_q  <= in_Req1_Type;
                        byreg_q <= in_Req1_ByReg;
                        amt_q   <= in_Req1_Amt;
                        c_q     <= in_Req1_C;
                        id_q    <= ID_ADDR;
                        last    <= ID_ADDR;
                        state   <= SS_SHIFT;
                    end
                end
                SS_SHIFT: begin
                    out_Res_Op2   <= bypass ? bypass_val : sh_val;
                    out_Res_Carry <= bypass ? bypass_carry : sh_carry;
                    out_Res_Id    <= id_q;
                    out_Res_Valid <= 1'b1;
                    state         <= SS_DONE;
                end
                SS_DONE: begin
                    if (in_Res_Ready) begin
                        out_Res_Valid <= 1'b0;
                        state         <= SS_IDLE;
                    end
                end
                default: state <= SS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_scheduler.sv
// Directed self-checking bench for shifter_scheduler.
module tb_shifter_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, rdy0, rdy1;
    logic [31:0] val0, val1;
    logic [1:0]  typ0, typ1;
    logic        br0, br1, c0, c1;
    logic [7:0]  amt0, amt1;
    logic        res_valid, res_ready, res_carry, res_id;
    logic [31:0] res_op2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shifter_scheduler dut (
        .in_Clk        (clk),
        .in_Reset      (rst),
        .in_Req0_Valid (v0),
        .out_Req0_Ready(rdy0),
        .in_Req0_Val   (val0),
        .in_Req0_Type  (typ0),
        .in_Req0_ByReg (br0),
        .in_Req0_Amt   (amt0),
        .in_Req0_C     (c0),
        .in_Req1_Valid (v1),
        .out_Req1_Ready(rdy1),
        .in_Req1_Val   (val1),
        .in_Req1_Type  (typ1),
        .in_Req1_ByReg (br1),
        .in_Req1_Amt   (amt1),
        .in_Req1_C     (c1),
        .out_Res_Valid (res_valid),
        .in_Res_Ready  (res_ready),
        .out_Res_Op2   (res_op2),
        .out_Res_Carry (res_carry),
        .out_Res_Id    (res_id)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic [1:0] t, input logic br,
                         input logic [7:0] a, input logic [31:0] v,
                         input logic c);
        if (p == 0) begin
            v0 = 1'b1; typ0 = t; br0 = br; amt0 = a; val0 = v; c0 = c;
        end else begin
            v1 = 1'b1; typ1 = t; br1 = br; amt1 = a; val1 = v; c1 = c;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; res_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_op(input string tag, input int p, input logic [1:0] t,
                          input logic br, input logic [7:0] a,
                          input logic [31:0] v, input logic c,
                          input logic [31:0] e_op2, input logic e_c,
                          input bit consume);
        bit got = 0;
        @(negedge clk);
        drive(p, t, br, a, v, c);
        #1;
        for (int n = 0; n < 10; n++) begin
            if (p == 0 ? rdy0 : rdy1) begin
                got = 1;
                break;
            end
            @(negedge clk); #1;
        end
        check({tag, "_hs"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        val0 = ~val0; val1 = ~val1; amt0 = ~amt0; amt1 = ~amt1;
        typ0 = ~typ0; typ1 = ~typ1; c0 = ~c0; c1 = ~c1;
        @(negedge clk);
        check({tag, "_v1"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        check({tag, "_v2"}, 32'(res_valid), 32'd1);
        check({tag, "_op2"}, res_op2, e_op2);
        check({tag, "_c"}, 32'(res_carry), 32'(e_c));
        check({tag, "_id"}, 32'(res_id), 32'(p));
        if (consume) begin
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            check({tag, "_rel"}, 32'(res_valid), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ids [4];
        int nid;
        rst = 1'b1; res_ready = 1'b0;
        v0 = 1'b1; v1 = 1'b1;
        val0 = '0; val1 = '0; typ0 = '0; typ1 = '0;
        br0 = 0; br1 = 0; amt0 = '0; amt1 = '0; c0 = 0; c1 = 0;
        @(negedge clk); #1;
        check("rst_rdy0", 32'(rdy0), 32'd0);
        check("rst_rdy1", 32'(rdy1), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_op2", res_op2, 32'd0);
        check("rst_carry", 32'(res_carry), 32'd0);
        check("rst_id", 32'(res_id), 32'd0);
        do_reset();

        run_op("byp0", 0, 2'd0, 1, 8'd0, 32'd2, 1, 32'd2, 1, 1);
        run_op("lsl32", 0, 2'd0, 1, 8'd32, 32'h3, 0, 32'h0, 1, 1);
        run_op("lsl33", 1, 2'd0, 1, 8'd33, 32'h3, 1, 32'h0, 0, 1);
        run_op("ror36", 0, 2'd3, 1, 8'd36, 32'd200, 0, 32'h8000000C, 1, 1);
        run_op("ror64", 1, 2'd3, 1, 8'd64, 32'h80000001, 0,
               32'h80000001, 1, 1);
        run_op("asr40", 0, 2'd2, 1, 8'd40, 32'hFFC00000, 0,
               32'hFFFFFFFF, 1, 1);
        run_op("lsr48", 0, 2'd1, 1, 8'd48, 32'hFFFFFFFF, 1, 32'h0, 0, 1);
        run_op("reg_lsr32", 1, 2'd1, 1, 8'd32, 32'h80000000, 0, 32'h0, 1, 1);
        run_op("imm_lsl5", 0, 2'd0, 0, 8'd5, 32'h0F000001, 0,
               32'hE0000020, 1, 1);
        run_op("imm_lsr0", 1, 2'd1, 0, 8'd0, 32'h80000000, 0, 32'h0, 1, 1);
        run_op("imm_rrx", 0, 2'd3, 0, 8'd0, 32'h3, 1, 32'h80000001, 1, 1);
        run_op("reg_lsl4", 1, 2'd0, 1, 8'd4, 32'h1000000F, 0,
               32'h000000F0, 1, 1);

        // backpressure: result held in DONE for five cycles
        run_op("bp", 1, 2'd1, 1, 8'd4, 32'h000000F8, 0, 32'h0000000F, 1, 0);
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_op2", res_op2, 32'h0000000F);
            check("bp_carry", 32'(res_carry), 32'd1);
            check("bp_id", 32'(res_id), 32'd1);
            check("bp_rdy", {30'd0, rdy1, rdy0}, 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("bp_rel_valid", 32'(res_valid), 32'd0);
        check("bp_rel_rdy0", 32'(rdy0), 32'd1);
        v0 = 1'b0; v1 = 1'b0;

        // arbitration from reset with both ports always valid
        do_reset();
        v0 = 1'b1; v1 = 1'b1; res_ready = 1'b1;
        nid = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            check("arb_both", 32'(rdy0 & rdy1), 32'd0);
            if (res_valid && nid < 4) begin
                ids[nid] = 32'(res_id);
                nid++;
            end
        end
        check("arb_n", 32'(nid), 32'd4);
        check("arb_id0", ids[0], 32'd0);
        check("arb_id1", ids[1], 32'd1);
        check("arb_id2", ids[2], 32'd0);
        check("arb_id3", ids[3], 32'd1);
        v0 = 1'b0; v1 = 1'b0; res_ready = 1'b0;

        // reset pulsed while in SHIFT after port 1 was granted
        do_reset();
        @(negedge clk);
        drive(1, 2'd0, 1, 8'd1, 32'h1, 0);
        @(posedge clk); #1;
        v1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rmid_valid", 32'(res_valid), 32'd0);
        check("rmid_op2", res_op2, 32'd0);
        @(posedge clk); #1;
        check("rmid_valid2", 32'(res_valid), 32'd0);
        v0 = 1'b1; v1 = 1'b1;
        #1;
        check("rmid_rdy0", 32'(rdy0), 32'd1);
        check("rmid_rdy1", 32'(rdy1), 32'd0);
        v0 = 1'b0; v1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
